// File: rtl/serial_rx_framer.sv
// rtl/serial_rx_framer.sv - oversampling 8N1 serial receiver with framing/overrun flags
module serial_rx_framer #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_full,
  output logic                 rx_busy,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int MID = OVERSAMPLE / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          sample_cnt;
  logic [BW-1:0]          bit_cnt;
  logic                   samp_a, samp_b, vote;
  logic                   at_vote, at_end, bit_last;
  logic                   frame_good, frame_bad;
  logic [DATA_BITS-1:0]   shreg;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  // The third vote sample is the live rx_s, so every mid-bit decision is taken one count past centre.
  assign vote     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign at_vote  = os_tick && (sample_cnt == CW'(MID + 1));
  assign at_end   = os_tick && (sample_cnt == CW'(OVERSAMPLE - 1));
  assign bit_last = (bit_cnt == BW'(DATA_BITS - 1));
  assign rx_busy  = (state != IDLE);

  // Input synchronizer; idles high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and frame-completion strobes.
  always_comb begin
    state_next = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      IDLE:  if (os_tick && !rx_s) state_next = START;
      START: begin
        if (at_vote && vote) state_next = IDLE;
        else if (at_end)     state_next = DATA;
      end
      DATA:  if (at_end && bit_last) state_next = STOP;
      STOP: begin
        if (at_vote) begin
          state_next = IDLE;
          frame_good = vote;
          frame_bad  = !vote;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample counter runs only while framing; IDLE holds it at zero so START begins at count 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              sample_cnt <= '0;
    else if (state == IDLE)  sample_cnt <= '0;
    else if (at_end)         sample_cnt <= '0;
    else if (os_tick)        sample_cnt <= sample_cnt + 1'b1;
  end

  // Bit counter advances at the end of each data bit period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              bit_cnt <= '0;
    else if (state != DATA)  bit_cnt <= '0;
    else if (at_end)         bit_cnt <= bit_cnt + 1'b1;
  end

  // First two majority samples, captured just before and at the bit centre.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (os_tick) begin
      if (sample_cnt == CW'(MID - 1)) samp_a <= rx_s;
      if (sample_cnt == CW'(MID))     samp_b <= rx_s;
    end
  end

  // Data bits arrive LSB first, so each vote enters at the MSB and shifts down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       shreg <= '0;
    else if (state == DATA && at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

  // Output register and flags; a completing frame takes priority over a same-cycle rd_ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_full     <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_good) begin
        rx_data <= shreg;
        rx_full <= 1'b1;
        if (rx_full && !rd_ack) overrun <= 1'b1;
      end else if (rd_ack) begin
        rx_full <= 1'b0;
      end
      if (frame_bad) framing_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_rx_framer.sv
// tb/tb_serial_rx_framer.sv - self-checking bench for serial_rx_framer
module tb_serial_rx_framer;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       reset;
  logic       os_tick;
  logic       rx;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] prev_data = 8'h00;
  logic       prev_full = 1'b0;
  logic       busy_seen;
  logic       full_dropped;
  logic       watch_full;

  typedef struct {
    logic [7:0] data;
    logic       exp_full;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[4];

  serial_rx_framer #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .os_tick(os_tick), .rx(rx), .rd_ack(rd_ack),
    .rx_data(rx_data), .rx_full(rx_full), .rx_busy(rx_busy),
    .framing_err(framing_err), .overrun(overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // os_tick every 4 clocks, so one bit period is 64 clocks.
  initial begin
    int div;
    div = 0;
    os_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      os_tick = (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a new byte is either a rising rx_full or a changed rx_data while full.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && rx_full && (!prev_full || rx_data !== prev_data)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", rx_data, 32'hFFFF_FFFF);
        end else begin
          check("sb_byte", rx_data, exp_q.pop_front());
        end
      end
      if (rx_busy) busy_seen = 1'b1;
      if (watch_full && !rx_full) full_dropped = 1'b1;
      prev_full = rx_full;
      prev_data = rx_data;
    end
  end

  task automatic drive_bit(input logic v, input logic glitch);
    rx = v;
    if (glitch) begin
      repeat (36) @(negedge clk);
      rx = !v;
      repeat (4) @(negedge clk);
      rx = v;
      repeat (BIT_CLKS - 40) @(negedge clk);
    end else begin
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic glitch);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    drive_bit(stop_v, 1'b0);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] last_good;
    int         waited;

    busy_seen    = 1'b0;
    full_dropped = 1'b0;
    watch_full   = 1'b0;
    vecs[0] = '{data: 8'hA5, exp_full: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
    vecs[1] = '{data: 8'h00, exp_full: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
    vecs[2] = '{data: 8'hFF, exp_full: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};
    vecs[3] = '{data: 8'h5A, exp_full: 1'b1, exp_ferr: 1'b0, exp_ovr: 1'b0};

    reset  = 1'b0;
    rx     = 1'b1;
    rd_ack = 1'b0;
    idle(3);
    check("rst_data", rx_data, 8'h00);
    check("rst_full", rx_full, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_ferr", framing_err, 1'b0);
    check("rst_ovr",  overrun, 1'b0);
    reset = 1'b1;
    idle(20);

    last_good = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, 1'b1, 1'b0);
      idle(8);
      check("vec_data", rx_data, vecs[i].data);
      check("vec_full", rx_full, vecs[i].exp_full);
      check("vec_ferr", framing_err, vecs[i].exp_ferr);
      check("vec_ovr",  overrun, vecs[i].exp_ovr);
      pulse_ack();
      check("vec_ack_clears_full", rx_full, 1'b0);
      last_good = vecs[i].data;
      idle(10);
    end

    // rd_ack with nothing stored is harmless
    pulse_ack();
    check("ack_empty_full", rx_full, 1'b0);
    check("ack_empty_data", rx_data, last_good);

    // Short low glitch while idle
    busy_seen = 1'b0;
    rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(2 * BIT_CLKS);
    check("glitch_busy_pulsed", busy_seen, 1'b1);
    check("glitch_busy_low", rx_busy, 1'b0);
    check("glitch_full", rx_full, 1'b0);
    check("glitch_ferr", framing_err, 1'b0);
    check("glitch_ovr",  overrun, 1'b0);

    // Stop bit forced low, then a good frame
    send_frame(8'h55, 1'b0, 1'b0);
    idle(3 * BIT_CLKS);
    check("ferr_set", framing_err, 1'b1);
    check("ferr_full", rx_full, 1'b0);
    check("ferr_data_kept", rx_data, last_good);
    check("ferr_busy", rx_busy, 1'b0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(8);
    check("after_ferr_data", rx_data, 8'h81);
    check("after_ferr_full", rx_full, 1'b1);
    check("ferr_sticky", framing_err, 1'b1);
    pulse_ack();
    idle(10);

    // Back-to-back frames without rd_ack
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(8);
    check("b2b_data", rx_data, 8'hC3);
    check("b2b_full", rx_full, 1'b1);
    check("b2b_ovr",  overrun, 1'b1);

    // Reset in the middle of the data bits of 0xFF
    idle(10);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_data", rx_data, 8'h00);
    check("midrst_full", rx_full, 1'b0);
    check("midrst_busy", rx_busy, 1'b0);
    check("midrst_ferr", framing_err, 1'b0);
    check("midrst_ovr",  overrun, 1'b0);
    idle(4);
    rx = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(20);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(8);
    check("post_rst_data", rx_data, 8'h12);
    check("post_rst_full", rx_full, 1'b1);
    idle(10);

    // rd_ack in the exact completion cycle of 0x77 while full
    exp_q.push_back(8'h77);
    full_dropped = 1'b0;
    watch_full   = 1'b1;
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        waited = 0;
        while (!rx_busy && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        if (rx_busy) begin
          // completion edge is 154 ticks (616 clocks) after the edge that raised rx_busy
          repeat (615) @(negedge clk);
          rd_ack = 1'b1;
          @(negedge clk);
          rd_ack = 1'b0;
        end else begin
          check("ack_race_busy_timeout", rx_busy, 1'b1);
        end
      end
    join
    idle(8);
    watch_full = 1'b0;
    check("ack_race_full", rx_full, 1'b1);
    check("ack_race_data", rx_data, 8'h77);
    check("ack_race_ovr",  overrun, 1'b0);
    check("ack_race_full_held", full_dropped, 1'b0);
    pulse_ack();
    idle(10);

    // One single-tick glitch inside each data bit
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b1);
    idle(8);
    check("vote_data", rx_data, 8'h0F);
    check("vote_full", rx_full, 1'b1);
    check("vote_ferr", framing_err, 1'b0);
    idle(10);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx_framer.md
Name: serial_rx_framer

Overview:
- Oversampling asynchronous-serial receiver: the stage directly downstream of the serial transmit link that feeds the on-board serial datapath.
- Runs on one system clock and uses a 16x-baud sample strobe from the existing clock-counter chain as an enable, not as a clock.
- Recovers 8N1 frames and holds each received byte in an output register for the consumer (LED/display or loopback logic).
- Flags framing and overrun errors.

Parameters:
- DATA_BITS, 8, payload bits per frame, LSB first.
- OVERSAMPLE, 16, sample strobes per bit period; must be even and at least 8.
- SYNC_STAGES, 2, flops in the rx input synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- os_tick  input  1  one-clk-wide strobe at OVERSAMPLE x baud; all sampling is qualified by it.
- rx  input  1  raw serial line; idle high; asynchronous to clk.
- rd_ack  input  1  consumer pulse that clears rx_full.
- rx_data  output  DATA_BITS  last accepted byte.
- rx_full  output  1  rx_data holds an unread byte.
- rx_busy  output  1  a frame is in progress (state not IDLE).
- framing_err  output  1  sticky; set when the stop bit is sampled low.
- overrun  output  1  sticky; set when a frame completes while rx_full=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; rx_data=0; rx_full=0; rx_busy=0; framing_err=0; overrun=0; synchronizer flops=1; counters=0.
- Reset asserted mid-frame aborts the frame immediately; the partial byte is discarded.
- rx passes through SYNC_STAGES flops; the FSM sees only rx_s. Only cycles with os_tick=1 advance the sample counter (0..OVERSAMPLE-1) and the bit counter (0..DATA_BITS-1).
- Each bit value is a majority vote of 3 samples taken at sample counts OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on os_tick with rx_s=0, go to START and clear the sample counter.
- START: at mid-bit, if the vote is 1 (glitch), return to IDLE with no flags. Otherwise, at sample count OVERSAMPLE-1, go to DATA with bit counter=0.
- DATA: at mid-bit, shift the vote into the MSB of the shift register (LSB-first line order). At the end of the bit period, increment the bit counter. After bit DATA_BITS-1 ends, go to STOP.
- STOP: evaluate the vote at mid-bit, then go to IDLE in the same cycle, without waiting for the end of the stop bit, so back-to-back frames resynchronize on the next falling edge.
  - Vote=1 (good frame): rx_data <= shift register; rx_full <= 1. If rx_full was already 1 and rd_ack is not asserted that cycle, set overrun=1; rx_data is still overwritten with the newest byte.
  - Vote=0: framing_err <= 1; rx_data and rx_full are unchanged.
- rd_ack:
  - A cycle with rd_ack=1 clears rx_full on the next edge.
  - If rd_ack and a good-frame completion occur in the same cycle, the completion wins: rx_full=1, no overrun.
  - rd_ack while rx_full=0 has no effect.
- framing_err and overrun clear only on reset.
- rx_busy = (state != IDLE), registered with the state.
- Latency: rx_full rises 1 clk after the os_tick that samples the stop-bit midpoint, about 9.5 bit periods after the start edge for DATA_BITS=8.
- Tolerates baud mismatch up to ±3% with OVERSAMPLE=16. A line held low continuously produces repeated framing_err frames of 0x00 that are never stored, then re-arms.

Test Plan:
- Reset, then send byte 0xA5 (8N1 at os_tick/16) -> rx_full=1, rx_data=0xA5, framing_err=0, overrun=0. Then rd_ack pulse -> rx_full=0 on the next clk.
- Send 0x3C then 0xC3 back-to-back with no idle gap and no rd_ack -> rx_data=0xC3, rx_full=1, overrun=1.
- Low glitch on rx of 4 os_tick periods while IDLE -> FSM returns to IDLE; rx_full=0, no flags, rx_busy pulses then drops.
- Frame 0x55 with the stop bit forced low -> framing_err=1, rx_full=0, rx_data keeps its previous value. A following valid 0x81 -> rx_data=0x81, framing_err stays 1.
- Assert reset midway through the data bits of 0xFF -> all outputs 0 immediately. After release, a new 0x12 is received correctly.
- rd_ack asserted in the exact cycle a second frame 0x77 completes while rx_full=1 -> rx_full=1, rx_data=0x77, overrun=0. Also send 0x0F with 1 single-tick glitch inside each bit -> the majority vote still yields 0x0F.
